rgb_axis_bridge: RTL and testbench
==================================

# rgb_axis_bridge

Converts the demosaiced RGB video-bus output of the OV5640 capture pipeline (24-bit pixel, vsync, active) into an AXI4-Stream video master for the VDMA write channel. It sits directly downstream of the capture/CFA stage.
- Frame start is marked on `m_axis_tuser` and end of line on `m_axis_tlast`.
- Sink backpressure is absorbed in an internal FIFO.
- On overflow, the rest of the current frame is dropped and the block resynchronises on the next vsync.

## Interface
Parameters:
- `DATA_WIDTH`, 24, pixel width (3 × 8-bit components, ordering passed through untouched)
- `FIFO_DEPTH`, 32, FIFO entries; power of two, ≥ 4

Ports:
- `clk`  in  1  pixel clock, same clock as the capture stage
- `rst`  in  1  asynchronous, active-high reset
- `in_data`  in  DATA_WIDTH  RGB pixel, valid when `in_active`=1
- `in_vsync`  in  1  frame sync, level high between frames
- `in_active`  in  1  pixel valid; high for the contiguous pixels of one line
- `m_axis_tdata`  out  DATA_WIDTH  pixel
- `m_axis_tvalid`  out  1  AXI4-Stream valid
- `m_axis_tready`  in  1  AXI4-Stream ready
- `m_axis_tuser`  out  1  start of frame (first pixel of frame)
- `m_axis_tlast`  out  1  end of line (last pixel of line)
- `overflow`  out  1  sticky: a frame was truncated due to a full FIFO
- `overflow_clr`  in  1  synchronous clear of `overflow`

## Operation
- States: WAIT_SOF, PASS, DROP. Reset state is WAIT_SOF.
- **WAIT_SOF**
  - Pixels are discarded.
  - `in_vsync`=1 arms `sof_pend` and moves to PASS.
- **PASS**
  - Each pixel with `in_active`=1 is loaded into a one-entry hold register (`hold_valid`=1).
  - If the hold register is already full on that cycle, its old content is written to the FIFO with eol=0.
  - On the first cycle with `in_active`=0 and `hold_valid`=1, the held pixel is written with eol=1 and `hold_valid` is cleared.
  - The written entry carries sof=`sof_pend`; `sof_pend` clears when an entry with sof=1 is written.
  - `in_vsync`=1 re-arms `sof_pend` (no state change).
- **DROP**
  - Pixels are discarded and `hold_valid` is cleared.
  - `in_vsync`=1 moves to PASS and arms `sof_pend`.
- **FIFO entry layout**: {sof, eol, data}, width DATA_WIDTH+2.
- **Full FIFO**
  - A write is blocked whenever count == FIFO_DEPTH, even if a read happens in the same cycle.
  - A blocked write discards the pixel, sets `overflow`, and moves to DROP.
  - Entries already queued drain normally, so the truncated line ends without tlast.
- **vsync during a line** (`in_vsync`=1 while `hold_valid`=1): the held pixel is flushed with eol=1 in that cycle, then the vsync takes effect.
- **Single-pixel line**: one beat with tlast=1; tuser=1 as well if it is the first pixel of the frame.
- **`overflow`**: set has priority over `overflow_clr` in the same cycle.
- **Output side**: first-word-fall-through from the FIFO through a registered output stage.
  - `m_axis_tvalid` stays high until the handshake completes.
  - tdata/tuser/tlast are stable while tvalid=1 and tready=0.
- **FIFO count**: width clog2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- **Reset values** (all outputs 0):
  - `m_axis_tvalid`, `m_axis_tuser`, `m_axis_tlast`, `m_axis_tdata`, `overflow`.
  - FIFO empty, `hold_valid`=0, `sof_pend`=0.

## Timing
- Pixel sampled with `in_active`=1 at edge N:
  - it is written to the FIFO at edge N+1 at the earliest (next pixel, or the falling edge of `in_active`);
  - it is visible on `m_axis_*` after edge N+2 when the FIFO is empty and tready=1.
- Sustained throughput is 1 pixel/clk when `m_axis_tready`=1 continuously; the FIFO never fills.
- `in_vsync` is sampled each cycle. A one-cycle pulse is sufficient.
- Asynchronous `rst` mid-frame:
  - all state is cleared immediately and `m_axis_tvalid` falls with no completing handshake;
  - after release the block waits in WAIT_SOF for the next vsync.

## Structure
- Shared package `ov5640_pkg`:
  - `RGB_W`=24;
  - state enum {WAIT_SOF, PASS, DROP};
  - entry-width constant `AXIS_ENTRY_W` = `RGB_W`+2.
- One sub-module, `pixel_fifo`: synchronous FWFT FIFO (DEPTH, WIDTH parameters; wr_en/full/rd_en/empty/dout/count).
- Top level holds the FSM, hold register, sof/eol tagging, overflow flag and AXIS output register.

## Test plan
- **Basic frame**
  - Stimulus: reset, vsync pulse, 3 lines of 4 pixels (0x000001…0x00000C) with 2-cycle gaps, tready=1.
  - Response: 12 beats in order; tuser=1 only on 0x000001; tlast=1 on 0x000004, 0x000008, 0x00000C.
- **Pixels before first vsync**: one line of 4 pixels after reset with no vsync → no beats output, `overflow`=0.
- **Backpressure**
  - Stimulus: tready=0 during one 20-pixel line with FIFO_DEPTH=32, then tready=1.
  - Response: all 20 beats delivered intact, tlast on the 20th, data stable while stalled.
- **Overflow**
  - Stimulus: tready=0, a 40-pixel line with FIFO_DEPTH=32.
  - Response:
    - `overflow`=1 after the 33rd write attempt;
    - after tready=1, exactly 32 beats with no tlast;
    - the following line is dropped;
    - after the next vsync, the next frame's first beat has tuser=1.
  - Then assert `overflow_clr` → `overflow`=0.
- **Single-pixel line and vsync mid-line**
  - Stimulus: a 1-pixel line right after vsync, then vsync asserted while a 3-pixel line is active.
  - Response:
    - the single pixel has tuser=1, tlast=1;
    - the truncated line ends with tlast=1 on its last accepted pixel;
    - the next pixel has tuser=1.
- **Reset mid-frame**: assert `rst` while tvalid=1 with 10 entries queued → tvalid=0 immediately; no beats until a new vsync plus line.

Source files
------------

// File: rtl/ov5640_pkg.sv
// Shared types and widths for the OV5640 capture-to-AXI4-Stream path.
package ov5640_pkg;
  localparam int RGB_W        = 24;
  localparam int AXIS_ENTRY_W = RGB_W + 2;

  typedef enum logic [1:0] {
    WAIT_SOF,
    PASS,
    DROP
  } state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO with a one-ahead read port so the
// consumer can reload its output register on the same edge it pops.
module pixel_fifo
  import ov5640_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = AXIS_ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  input  logic                     rd_en,
  output logic                     empty,
  output logic [WIDTH-1:0]         dout,
  output logic [WIDTH-1:0]         dout_ahead,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [AW-1:0]    w_rd_ptr_inc;
  logic             w_wr;
  logic             w_rd;

  assign full         = (r_count == FULL_CNT);
  assign empty        = (r_count == '0);
  assign count        = r_count;
  assign w_wr         = wr_en && !full;
  assign w_rd         = rd_en && !empty;
  assign w_rd_ptr_inc = r_rd_ptr + AW'(1);
  assign dout         = r_mem[r_rd_ptr];
  assign dout_ahead   = r_mem[w_rd_ptr_inc];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Full blocks writes even when a read happens in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/rgb_axis_bridge.sv
// RGB video bus (pixel/vsync/active) to AXI4-Stream video master with
// frame-level drop and resync on FIFO overflow.
module rgb_axis_bridge
  import ov5640_pkg::*;
#(
  parameter int DATA_WIDTH = RGB_W,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_vsync,
  input  logic                  in_active,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  overflow,
  input  logic                  overflow_clr
);
  localparam int ENTRY_W = DATA_WIDTH + 2;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_valid;
  logic                  r_sof_pend;
  logic                  r_overflow;

  logic                  w_push;
  logic                  w_push_eol;
  logic                  w_load_hold;
  logic                  w_clear_hold;
  logic                  w_arm;
  logic                  w_ovf_set;
  logic                  w_fifo_wr;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [ENTRY_W-1:0]    w_fifo_din;
  logic [ENTRY_W-1:0]    w_fifo_dout;
  logic [ENTRY_W-1:0]    w_fifo_ahead;
  logic [CNT_W-1:0]      w_fifo_count;

  logic                  r_tvalid;
  logic                  r_tuser;
  logic                  r_tlast;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  w_pop;

  // The pixel presented in a vsync cycle is treated as blanking and discarded.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_push_eol   = 1'b0;
    w_load_hold  = 1'b0;
    w_clear_hold = 1'b0;
    w_arm        = 1'b0;
    w_ovf_set    = 1'b0;
    case (r_state)
      WAIT_SOF: begin
        if (in_vsync) begin
          w_arm        = 1'b1;
          w_state_next = PASS;
        end
      end
      PASS: begin
        if (in_vsync) begin
          w_arm = 1'b1;
          if (r_hold_valid) begin
            w_push       = 1'b1;
            w_push_eol   = 1'b1;
            w_clear_hold = 1'b1;
          end
        end else if (in_active) begin
          w_push      = r_hold_valid;
          w_load_hold = 1'b1;
        end else if (r_hold_valid) begin
          w_push       = 1'b1;
          w_push_eol   = 1'b1;
          w_clear_hold = 1'b1;
        end
        if (w_push && w_fifo_full) begin
          w_ovf_set    = 1'b1;
          w_load_hold  = 1'b0;
          w_clear_hold = 1'b1;
          if (!in_vsync) begin
            w_state_next = DROP;
          end
        end
      end
      DROP: begin
        w_clear_hold = 1'b1;
        if (in_vsync) begin
          w_arm        = 1'b1;
          w_state_next = PASS;
        end
      end
      default: begin
        w_state_next = WAIT_SOF;
      end
    endcase
  end

  assign w_fifo_wr  = w_push && !w_fifo_full;
  assign w_fifo_din = {r_sof_pend, w_push_eol, r_hold_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= WAIT_SOF;
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_sof_pend   <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load_hold) begin
        r_hold_data  <= in_data;
        r_hold_valid <= 1'b1;
      end else if (w_clear_hold) begin
        r_hold_valid <= 1'b0;
      end
      if (w_arm) begin
        r_sof_pend <= 1'b1;
      end else if (w_fifo_wr) begin
        r_sof_pend <= 1'b0;
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (w_fifo_wr),
    .din        (w_fifo_din),
    .full       (w_fifo_full),
    .rd_en      (w_pop),
    .empty      (w_fifo_empty),
    .dout       (w_fifo_dout),
    .dout_ahead (w_fifo_ahead),
    .count      (w_fifo_count)
  );

  // The output register mirrors the FIFO head; an entry leaves the FIFO only
  // on a completed handshake, so the FIFO alone bounds the buffered pixels.
  assign w_pop = r_tvalid && m_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tvalid <= 1'b0;
      r_tuser  <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else if (w_pop) begin
      r_tvalid                    <= (w_fifo_count > CNT_W'(1));
      {r_tuser, r_tlast, r_tdata} <= w_fifo_ahead;
    end else begin
      r_tvalid                    <= !w_fifo_empty;
      {r_tuser, r_tlast, r_tdata} <= w_fifo_dout;
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tdata  = r_tdata;
  assign overflow      = r_overflow;
endmodule

// File: tb/tb_rgb_axis_bridge.sv
// Directed bench for rgb_axis_bridge: beats are collected on the falling edge
// and compared against hand-computed {tuser, tlast, tdata} sequences.
module tb_rgb_axis_bridge;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_vsync = 1'b0;
  logic          in_active = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tuser;
  logic          m_axis_tlast;
  logic          overflow;
  logic          overflow_clr = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW+1:0] beat_q[$];

  rgb_axis_bridge #(.DATA_WIDTH(DW), .FIFO_DEPTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_vsync      (in_vsync),
    .in_active     (in_active),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m_axis_tvalid && m_axis_tready) begin
      beat_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      $display("[TB] beat tuser=%0b tlast=%0b tdata=%06h", m_axis_tuser, m_axis_tlast, m_axis_tdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic u, input logic l, input logic [DW-1:0] d);
    logic [63:0] got;
    if (beat_q.size() > 0) got = {38'b0, beat_q.pop_front()};
    else                   got = '1;
    chk(tag, got, {38'b0, u, l, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_active = 1'b0;
    in_vsync = 1'b0;
    overflow_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic vsync_pulse();
    in_vsync = 1'b1;
    tick();
    in_vsync = 1'b0;
  endtask

  task automatic send_line(input logic [DW-1:0] start, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      in_active = 1'b1;
      in_data   = start + DW'(i);
      tick();
    end
    in_active = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic drain(input int cycles);
    m_axis_tready = 1'b1;
    repeat (cycles) tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and basic frame
    do_reset();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tuser", 64'(m_axis_tuser), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    beat_q.delete();
    m_axis_tready = 1'b1;
    vsync_pulse();
    send_line(24'h000001, 4, 2);
    send_line(24'h000005, 4, 2);
    send_line(24'h000009, 4, 2);
    drain(10);
    chk("basic_count", 64'(beat_q.size()), 64'd12);
    for (int i = 0; i < 12; i++)
      chk_beat("basic_beat", i == 0, (i % 4) == 3, DW'(i + 1));

    // Pixels before the first vsync are discarded
    do_reset();
    beat_q.delete();
    m_axis_tready = 1'b1;
    send_line(24'h000080, 4, 2);
    drain(6);
    chk("novsync_count", 64'(beat_q.size()), 64'd0);
    chk("novsync_overflow", 64'(overflow), 64'd0);

    // Backpressure over a 20-pixel line
    beat_q.delete();
    vsync_pulse();
    m_axis_tready = 1'b0;
    send_line(24'h000100, 20, 3);
    chk("bp_stall_head", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), {37'b0, 1'b1, 1'b1, 1'b0, 24'h000100});
    repeat (5) tick();
    chk("bp_stall_stable", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), {37'b0, 1'b1, 1'b1, 1'b0, 24'h000100});
    drain(25);
    chk("bp_count", 64'(beat_q.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      chk_beat("bp_beat", i == 0, i == 19, 24'h000100 + DW'(i));

    // Overflow on a 40-pixel line with the sink stalled
    beat_q.delete();
    m_axis_tready = 1'b0;
    vsync_pulse();
    for (int k = 0; k < 40; k++) begin
      in_active = 1'b1;
      in_data   = 24'h000200 + DW'(k);
      tick();
      if (k == 32) chk("ovf_before_33rd", 64'(overflow), 64'd0);
      if (k == 33) chk("ovf_after_33rd", 64'(overflow), 64'd1);
    end
    in_active = 1'b0;
    repeat (3) tick();
    send_line(24'h000300, 5, 2);
    drain(40);
    chk("ovf_count", 64'(beat_q.size()), 64'd32);
    for (int i = 0; i < 32; i++)
      chk_beat("ovf_beat", i == 0, 1'b0, 24'h000200 + DW'(i));
    vsync_pulse();
    send_line(24'h000400, 3, 2);
    drain(6);
    chk("resync_count", 64'(beat_q.size()), 64'd3);
    chk_beat("resync_beat0", 1'b1, 1'b0, 24'h000400);
    chk_beat("resync_beat1", 1'b0, 1'b0, 24'h000401);
    chk_beat("resync_beat2", 1'b0, 1'b1, 24'h000402);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // Single-pixel line with latency check, then vsync mid-line
    beat_q.delete();
    m_axis_tready = 1'b1;
    vsync_pulse();
    in_active = 1'b1;
    in_data   = 24'h000500;
    tick();
    in_active = 1'b0;
    tick();
    chk("lat_n1_tvalid", 64'(m_axis_tvalid), 64'd0);
    tick();
    chk("lat_n2_beat", 64'({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}), {37'b0, 1'b1, 1'b1, 1'b1, 24'h000500});
    repeat (2) tick();
    in_active = 1'b1;
    in_data   = 24'h000501;
    tick();
    in_data   = 24'h000502;
    tick();
    in_vsync  = 1'b1;
    in_data   = 24'h000503;
    tick();
    in_vsync  = 1'b0;
    in_active = 1'b0;
    repeat (2) tick();
    send_line(24'h000504, 2, 2);
    drain(6);
    chk("midvs_count", 64'(beat_q.size()), 64'd5);
    chk_beat("single_px", 1'b1, 1'b1, 24'h000500);
    chk_beat("midvs_beat0", 1'b0, 1'b0, 24'h000501);
    chk_beat("midvs_beat1", 1'b0, 1'b1, 24'h000502);
    chk_beat("midvs_newsof", 1'b1, 1'b0, 24'h000504);
    chk_beat("midvs_eol", 1'b0, 1'b1, 24'h000505);

    // Asynchronous reset with 10 entries queued
    beat_q.delete();
    vsync_pulse();
    m_axis_tready = 1'b0;
    send_line(24'h000600, 10, 3);
    chk("arst_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
    tick();
    rst = 1'b0;
    m_axis_tready = 1'b1;
    send_line(24'h000700, 4, 2);
    drain(6);
    chk("arst_no_beats", 64'(beat_q.size()), 64'd0);
    vsync_pulse();
    send_line(24'h000710, 2, 2);
    drain(6);
    chk("arst_after_count", 64'(beat_q.size()), 64'd2);
    chk_beat("arst_beat0", 1'b1, 1'b0, 24'h000710);
    chk_beat("arst_beat1", 1'b0, 1'b1, 24'h000711);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
